trees_stream_ctrl: RTL and testbench



---
 rtl/trees_pkg.sv | 22 ++
 rtl/trees_feat_addr_gen.sv | 43 ++++
 rtl/trees_stream_ctrl.sv | 160 ++++++++++++++++
 tb/tb_trees_stream_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trees_pkg.sv
// Types and constants shared by the tree inference engine and its batch stream controller.
package trees_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StSettle,
        StDrain
    } ctrl_state_t;

    localparam int unsigned N_FEATURE_DEF = 32;
    localparam int unsigned WPS           = N_FEATURE_DEF / 2;
    localparam int unsigned PRED_PER_WORD = 8;
    localparam int unsigned PRED_SHIFT    = $clog2(PRED_PER_WORD);

    function automatic int unsigned burst_len_w(input int unsigned max_burst);
        return $clog2(max_burst);
    endfunction

endpackage

// File: rtl/trees_feat_addr_gen.sv
// Sample/word counter for feature ingest; flags the final beat of the batch.
module trees_feat_addr_gen #(
    parameter int unsigned WORDS     = 16,
    parameter int unsigned WORD_BITS = 4,
    parameter int unsigned LEN_W     = 13
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_advance,
    input  logic [LEN_W-1:0]     i_burst_len,
    output logic [LEN_W-1:0]     o_sample,
    output logic [WORD_BITS-1:0] o_word,
    output logic                 o_last
);

    logic [LEN_W-1:0]     r_sample;
    logic [WORD_BITS-1:0] r_word;
    logic                 w_word_wrap;

    assign w_word_wrap = (r_word == WORD_BITS'(WORDS - 1));
    assign o_last      = w_word_wrap && (r_sample == i_burst_len - LEN_W'(1));
    assign o_sample    = r_sample;
    assign o_word      = r_word;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sample <= '0;
            r_word   <= '0;
        end else if (i_clear) begin
            r_sample <= '0;
            r_word   <= '0;
        end else if (i_advance) begin
            if (w_word_wrap) begin
                r_word   <= '0;
                r_sample <= r_sample + LEN_W'(1);
            end else begin
                r_word <= r_word + WORD_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/trees_stream_ctrl.sv
// Batch controller: loads features into the tree engine, starts it, then streams predictions out.
module trees_stream_ctrl
    import trees_pkg::*;
#(
    parameter int unsigned N_FEATURE = N_FEATURE_DEF,
    parameter int unsigned MAX_BURST = 5000,
    parameter int unsigned WPS_BITS  = $clog2(N_FEATURE / 2)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [$clog2(MAX_BURST)-1:0]           cfg_burst_len,
    output logic                                   cfg_err,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [63:0]                            in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [63:0]                            out_data,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   eng_load_features,
    output logic [$clog2(MAX_BURST*N_FEATURE)-1:0] eng_feature_addr,
    output logic [63:0]                            eng_features,
    output logic [$clog2(MAX_BURST)-1:0]           eng_burst_len,
    output logic                                   eng_start,
    input  logic                                   eng_done,
    output logic [$clog2(MAX_BURST)-1:0]           eng_prediction_addr,
    input  logic [63:0]                            eng_prediction
);

    localparam int unsigned LEN_W  = burst_len_w(MAX_BURST);
    localparam int unsigned ADDR_W = $clog2(MAX_BURST * N_FEATURE);
    localparam int unsigned NW_W   = LEN_W + 1;
    localparam int unsigned WORDS  = N_FEATURE / 2;

    ctrl_state_t r_state, w_state_next;

    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_pred_addr;
    logic [NW_W-1:0]     r_nw;
    logic                r_cfg_err;
    logic                r_load;
    logic                r_start;
    logic                r_out_valid;
    logic                r_out_last;
    logic [ADDR_W-1:0]   r_feat_addr;
    logic [63:0]         r_features;
    logic [63:0]         r_out_data;

    logic                w_cfg_ok;
    logic                w_cfg_take;
    logic                w_beat;
    logic                w_last_beat;
    logic                w_out_hs;
    logic                w_load_word;
    logic [NW_W-1:0]     w_nw;
    logic [LEN_W-1:0]    w_sample;
    logic [WPS_BITS-1:0] w_word;

    assign w_cfg_ok    = (cfg_burst_len != '0) && (NW_W'(cfg_burst_len) <= NW_W'(MAX_BURST));
    assign w_cfg_take  = (r_state == StIdle) && cfg_valid && w_cfg_ok;
    assign w_beat      = (r_state == StLoad) && in_valid;
    assign w_out_hs    = r_out_valid && out_ready;
    assign w_nw        = (NW_W'(r_len) + NW_W'(PRED_PER_WORD - 1)) >> PRED_SHIFT;
    // SETTLE fetches word 0; each non-final handshake fetches the next one.
    assign w_load_word = (r_state == StSettle) || ((r_state == StDrain) && w_out_hs && !r_out_last);

    trees_feat_addr_gen #(
        .WORDS     (WORDS),
        .WORD_BITS (WPS_BITS),
        .LEN_W     (LEN_W)
    ) u_addr_gen (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clear     (w_cfg_take),
        .i_advance   (w_beat),
        .i_burst_len (r_len),
        .o_sample    (w_sample),
        .o_word      (w_word),
        .o_last      (w_last_beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_cfg_take) w_state_next = StLoad;
            StLoad:   if (w_beat && w_last_beat) w_state_next = StStart;
            StStart:  w_state_next = StRun;
            StRun:    if (eng_done) w_state_next = StSettle;
            StSettle: w_state_next = StDrain;
            StDrain:  if (w_out_hs && r_out_last) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_pred_addr <= '0;
            r_nw        <= '0;
            r_cfg_err   <= 1'b0;
            r_load      <= 1'b0;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_feat_addr <= '0;
            r_features  <= '0;
            r_out_data  <= '0;
        end else begin
            r_cfg_err <= (r_state == StIdle) && cfg_valid && !w_cfg_ok;
            r_load    <= w_beat;
            r_start   <= (r_state == StStart);
            if (w_cfg_take) begin
                r_len <= cfg_burst_len;
            end
            if (w_beat) begin
                r_feat_addr <= ADDR_W'(w_sample) * ADDR_W'(WORDS) + ADDR_W'(w_word);
                r_features  <= in_data;
            end
            if ((r_state == StRun) && eng_done) begin
                r_pred_addr <= '0;
                r_nw        <= w_nw;
            end
            if (w_load_word) begin
                r_out_data  <= eng_prediction;
                r_out_valid <= 1'b1;
                r_out_last  <= ({1'b0, r_pred_addr} == r_nw - NW_W'(1));
                r_pred_addr <= r_pred_addr + LEN_W'(1);
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign cfg_ready           = (r_state == StIdle) && !rst;
    assign in_ready            = (r_state == StLoad);
    assign busy                = (r_state != StIdle);
    assign cfg_err             = r_cfg_err;
    assign out_valid           = r_out_valid;
    assign out_data            = r_out_data;
    assign out_last            = r_out_last;
    assign eng_load_features   = r_load;
    assign eng_feature_addr    = r_feat_addr;
    assign eng_features        = r_features;
    assign eng_burst_len       = r_len;
    assign eng_start           = r_start;
    assign eng_prediction_addr = r_pred_addr;

endmodule

// File: tb/tb_trees_stream_ctrl.sv
// Directed bench for trees_stream_ctrl with a behavioural engine stand-in.
module tb_trees_stream_ctrl;

    localparam int LEN_W  = 13;
    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [LEN_W-1:0]  cfg_burst_len = '0;
    logic              cfg_err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [63:0]       in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [63:0]       out_data;
    logic              out_last;
    logic              busy;
    logic              eng_load_features;
    logic [ADDR_W-1:0] eng_feature_addr;
    logic [63:0]       eng_features;
    logic [LEN_W-1:0]  eng_burst_len;
    logic              eng_start;
    logic              eng_done = 1'b0;
    logic [LEN_W-1:0]  eng_prediction_addr;
    logic [63:0]       eng_prediction;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int last_wr_cyc = 0;
    int err_cnt = 0;
    bit busy_seen = 1'b0;
    int n_stall = 0;
    int stab_viol = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [63:0]       wr_data_q[$];
    logic [63:0]       got_data[$];
    logic              got_last[$];
    int                got_cyc[$];

    function automatic logic [63:0] pred_word(input logic [LEN_W-1:0] a);
        return {32'hC0DE_0000 | {19'h0, a}, 32'hF00D_0000 ^ {19'h0, a}};
    endfunction

    function automatic logic [63:0] beat_data(input int b);
        return {32'(b), 32'(b)};
    endfunction

    function automatic int count_bad_writes(input int n);
        int bad = 0;
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== beat_data(i)) bad++;
        end
        return bad;
    endfunction

    assign eng_prediction = pred_word(eng_prediction_addr);

    trees_stream_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_burst_len       (cfg_burst_len),
        .cfg_err             (cfg_err),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last),
        .busy                (busy),
        .eng_load_features   (eng_load_features),
        .eng_feature_addr    (eng_feature_addr),
        .eng_features        (eng_features),
        .eng_burst_len       (eng_burst_len),
        .eng_start           (eng_start),
        .eng_done            (eng_done),
        .eng_prediction_addr (eng_prediction_addr),
        .eng_prediction      (eng_prediction)
    );

    always #5 clk = ~clk;

    // Engine-side recorder, sampled on the inactive edge.
    always @(negedge clk) begin
        cyc++;
        if (eng_load_features) begin
            wr_addr_q.push_back(eng_feature_addr);
            wr_data_q.push_back(eng_features);
            last_wr_cyc = cyc;
        end
        if (eng_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (cfg_err) err_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic clear_capture();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic do_cfg(input logic [LEN_W-1:0] len);
        cfg_valid     = 1'b1;
        cfg_burst_len = len;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic feed(input int n, input int gap, output bit ok);
        int t;
        ok = 1'b1;
        for (int b = 0; b < n; b++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = beat_data(b);
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) ok = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_engine(output bit ok);
        int t = 0;
        while (!eng_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = eng_start;
        if (ok) begin
            repeat (3) @(negedge clk);
            eng_done = 1'b1;
            @(negedge clk);
            eng_done = 1'b0;
        end
    endtask

    // mode 0: out_ready held high; mode 1: ready alternates 0/1 while words are offered.
    task automatic drain(input int nw, input int mode, output bit ok);
        int t = 0;
        int ph = 0;
        bit held = 1'b0;
        logic [63:0] hd = '0;
        logic hl = 1'b0;
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        n_stall   = 0;
        stab_viol = 0;
        while (got_data.size() < nw && t < 200) begin
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (out_valid) begin
                out_ready = ph[0];
                ph++;
            end else begin
                out_ready = 1'b0;
            end
            if (held && out_valid && (out_data !== hd || out_last !== hl)) stab_viol++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_cyc.push_back(t);
                held = 1'b0;
            end else if (out_valid) begin
                n_stall++;
                held = 1'b1;
                hd   = out_data;
                hl   = out_last;
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        ok = (got_data.size() == nw);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cfg_ready, in_ready, busy, out_valid, out_last, cfg_err, eng_load_features, eng_start} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000000",
                {cfg_ready, in_ready, busy, out_valid, out_last, cfg_err, eng_load_features, eng_start});
        end
        n_cmp++;
        if ({eng_burst_len, eng_feature_addr, eng_prediction_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: got len %0d addr %0d paddr %0d want 0",
                eng_burst_len, eng_feature_addr, eng_prediction_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cfg_ready, busy, in_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b want 100", {cfg_ready, busy, in_ready});
        end
    endtask

    task automatic test_single();
        bit ok;
        int s0 = start_cnt;
        clear_capture();
        do_cfg(13'd1);
        n_cmp++;
        if (eng_burst_len !== 13'd1) begin
            n_bad++;
            $display("FAIL single_burst_len: got %0d want 1", eng_burst_len);
        end
        feed(16, 0, ok);
        run_engine(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single_start: got no eng_start want pulse");
        end
        drain(1, 0, ok);
        n_cmp++;
        if (wr_addr_q.size() !== 16 || count_bad_writes(16) !== 0) begin
            n_bad++;
            $display("FAIL single_writes: got %0d writes %0d bad want 16 writes 0 bad",
                wr_addr_q.size(), count_bad_writes(16));
        end
        n_cmp++;
        if (!ok || got_data[0] !== pred_word(13'd0) || got_last[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_out: got n=%0d data %h last %b want n=1 data %h last 1",
                got_data.size(), got_data[0], got_last[0], pred_word(13'd0));
        end
        n_cmp++;
        if (start_cnt - s0 !== 1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_end: got starts %0d valid %b busy %b want 1 0 0",
                start_cnt - s0, out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_capture();
        do_cfg(13'd9);
        feed(144, 0, ok);
        run_engine(ok);
        drain(2, 0, ok);
        n_cmp++;
        if (wr_addr_q.size() !== 144 || count_bad_writes(144) !== 0) begin
            n_bad++;
            $display("FAIL b2b_writes: got %0d writes %0d bad want 144 writes 0 bad",
                wr_addr_q.size(), count_bad_writes(144));
        end
        n_cmp++;
        if (!ok || got_data[0] !== pred_word(13'd0) || got_data[1] !== pred_word(13'd1)) begin
            n_bad++;
            $display("FAIL b2b_data: got n=%0d %h %h want %h %h", got_data.size(),
                got_data[0], got_data[1], pred_word(13'd0), pred_word(13'd1));
        end
        n_cmp++;
        if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_last: got %b %b want 0 1", got_last[0], got_last[1]);
        end
        n_cmp++;
        if (got_cyc[1] - got_cyc[0] !== 1) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d cycles want 1", got_cyc[1] - got_cyc[0]);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got busy %b want 0", busy);
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_cfg(13'd3);
        feed(48, 0, ok);
        run_engine(ok);
        drain(1, 1, ok);
        n_cmp++;
        if (!ok || got_data[0] !== pred_word(13'd0) || got_last[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_out: got n=%0d data %h last %b want n=1 data %h last 1",
                got_data.size(), got_data[0], got_last[0], pred_word(13'd0));
        end
        n_cmp++;
        if (n_stall !== 1 || stab_viol !== 0) begin
            n_bad++;
            $display("FAIL stall_hold: got stalls %0d unstable %0d want 1 0", n_stall, stab_viol);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_extra: got valid %b busy %b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_gaps();
        bit ok;
        clear_capture();
        do_cfg(13'd2);
        feed(32, 2, ok);
        run_engine(ok);
        n_cmp++;
        if (wr_addr_q.size() !== 32 || count_bad_writes(32) !== 0) begin
            n_bad++;
            $display("FAIL gaps_writes: got %0d writes %0d bad want 32 writes 0 bad",
                wr_addr_q.size(), count_bad_writes(32));
        end
        n_cmp++;
        if (start_cyc !== last_wr_cyc + 1) begin
            n_bad++;
            $display("FAIL gaps_start_time: got cycle %0d want %0d", start_cyc, last_wr_cyc + 1);
        end
        drain(1, 0, ok);
        n_cmp++;
        if (!ok || got_last[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL gaps_out: got n=%0d last %b want n=1 last 1", got_data.size(), got_last[0]);
        end
    endtask

    task automatic test_cfg_err();
        int e0 = err_cnt;
        int s0 = start_cnt;
        busy_seen = 1'b0;
        do_cfg(13'd0);
        n_cmp++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_len0: got err %b busy %b want 1 0", cfg_err, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse_width: got %b want 0", cfg_err);
        end
        do_cfg(13'd5001);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (err_cnt - e0 !== 2 || busy_seen !== 1'b0 || start_cnt - s0 !== 0) begin
            n_bad++;
            $display("FAIL err_summary: got errs %0d busy_seen %b starts %0d want 2 0 0",
                err_cnt - e0, busy_seen, start_cnt - s0);
        end
        do_cfg(13'd5000);
        n_cmp++;
        if (busy !== 1'b1 || cfg_err !== 1'b0 || eng_burst_len !== 13'd5000) begin
            n_bad++;
            $display("FAIL err_max_len: got busy %b err %b len %0d want 1 0 5000",
                busy, cfg_err, eng_burst_len);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        clear_capture();
        do_cfg(13'd1);
        feed(7, 0, ok);
        n_cmp++;
        if (eng_load_features !== 1'b1 || eng_feature_addr !== 18'd6) begin
            n_bad++;
            $display("FAIL midload_pre: got load %b addr %0d want 1 6", eng_load_features, eng_feature_addr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({cfg_ready, in_ready, busy, out_valid, eng_load_features, eng_start} !== 6'b0 ||
            eng_feature_addr !== '0 || eng_features !== '0 || eng_burst_len !== '0) begin
            n_bad++;
            $display("FAIL midload_reset: got flags %b addr %0d data %h len %0d want all 0",
                {cfg_ready, in_ready, busy, out_valid, eng_load_features, eng_start},
                eng_feature_addr, eng_features, eng_burst_len);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_capture();
        do_cfg(13'd1);
        feed(16, 0, ok);
        run_engine(ok);
        drain(1, 0, ok);
        n_cmp++;
        if (wr_addr_q.size() !== 16 || count_bad_writes(16) !== 0) begin
            n_bad++;
            $display("FAIL midload_restart: got %0d writes %0d bad want 16 writes 0 bad",
                wr_addr_q.size(), count_bad_writes(16));
        end
        n_cmp++;
        if (!ok || got_last[0] !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midload_out: got n=%0d last %b busy %b want 1 1 0",
                got_data.size(), got_last[0], busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_gaps();
        test_cfg_err();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
